// File: rtl/rom_fetch_unit_pkg.sv
// rtl/rom_fetch_unit_pkg.sv - shared widths, buffer depth and FSM encoding for the ROM fetch unit
package rom_fetch_unit_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 8;
    localparam int FETCH_BUF_DEPTH = 2;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/rom_fetch_unit_if.sv
// rtl/rom_fetch_unit_if.sv - valid/ready word stream carrying {addr, data} pairs to the consumer
interface rom_fetch_unit_if
    import rom_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/rom_fetch_unit_fetch_buffer.sv
// rtl/rom_fetch_unit_fetch_buffer.sv - 2-entry FIFO with registered head, flushable in one cycle
module fetch_buffer
    import rom_fetch_unit_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter int CNT_W = $clog2(FETCH_BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail;
    logic             do_pop;

    assign do_pop = pop && (count != CNT_W'(0));

    // head is the output register itself, so a push into an empty buffer is visible next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_W'(0);
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= CNT_W'(0);
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == CNT_W'(0)) head <= din;
                    else                    tail <= din;
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_W'(1);
                end
                2'b11: begin
                    if (count == CNT_W'(1)) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - PC sequencer for an asynchronous ROM with timed capture and jump redirect
module rom_fetch_unit
    import rom_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    rom_fetch_unit_if.master  out_if
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int               BUF_W    = $clog2(FETCH_BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    fetch_state_e              state, state_nxt;
    logic [ADDR_W-1:0]         pc, pc_nxt;
    logic [CNT_W-1:0]          wait_cnt, wait_cnt_nxt;
    logic [BUF_W-1:0]          buf_count;
    logic [ADDR_W+DATA_W-1:0]  head;
    logic                      pop, space, push, flush;

    assign rom_addr         = pc;
    assign out_if.out_valid = (buf_count != BUF_W'(0));
    assign out_if.out_addr  = head[ADDR_W+DATA_W-1:DATA_W];
    assign out_if.out_data  = head[DATA_W-1:0];

    // A pop at the same edge frees a slot, so a full buffer can still accept a capture
    assign pop   = out_if.out_valid && out_if.out_ready;
    assign space = (buf_count < BUF_W'(FETCH_BUF_DEPTH)) || pop;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        wait_cnt_nxt = wait_cnt;
        push         = 1'b0;
        flush        = 1'b0;
        if (jump_valid) begin
            flush        = 1'b1;
            pc_nxt       = jump_addr;
            wait_cnt_nxt = CNT_W'(0);
            state_nxt    = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == LAST_CNT) begin
                        if (space) begin
                            push         = 1'b1;
                            pc_nxt       = pc + ADDR_W'(1);
                            wait_cnt_nxt = CNT_W'(0);
                        end else begin
                            state_nxt = ST_HOLD;
                        end
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // rom_addr has not moved, so rom_data is still the settled word
                    if (space) begin
                        push         = 1'b1;
                        pc_nxt       = pc + ADDR_W'(1);
                        wait_cnt_nxt = CNT_W'(0);
                        state_nxt    = ST_WAIT;
                    end
                end
                default: state_nxt = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            pc       <= RESET_PC;
            wait_cnt <= CNT_W'(0);
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    fetch_buffer #(
        .WIDTH (ADDR_W + DATA_W),
        .CNT_W (BUF_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({pc, rom_data}),
        .count (buf_count),
        .head  (head)
    );

endmodule
